// File: rtl/ex_mem_pkg.sv
// Shared core definitions for the execute/memory pipeline register:
// widths, stall-vector bit positions, the NOP aluop and the stage payload.
package ex_mem_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned ALUOP_W = 8;
  localparam int unsigned CNT_W   = 2;
  localparam int unsigned STALL_W = 6;
  localparam int unsigned HILO_W  = 2 * DATA_W;

  localparam int unsigned STALL_EX  = 3;
  localparam int unsigned STALL_MEM = 4;

  localparam logic [ALUOP_W-1:0] ALUOP_NOP = ALUOP_W'(0);

  // Everything the memory stage receives from execute.
  typedef struct packed {
    logic [ADDR_W-1:0]  wd;
    logic               wreg;
    logic [DATA_W-1:0]  wdata;
    logic [DATA_W-1:0]  hi;
    logic [DATA_W-1:0]  lo;
    logic               whilo;
    logic [ALUOP_W-1:0] aluop;
    logic [DATA_W-1:0]  mem_addr;
    logic [DATA_W-1:0]  reg2;
  } ex_mem_pl_t;

  // Bubble: no write-backs, NOP operation, all data zero.
  function automatic ex_mem_pl_t bubble_pl();
    ex_mem_pl_t pl;
    pl       = '0;
    pl.aluop = ALUOP_NOP;
    return pl;
  endfunction

endpackage

// File: rtl/ex_mem_if.sv
// Execute-to-memory stage bus, including the accumulate state loop back to execute.
interface ex_mem_if;
  import ex_mem_pkg::*;

  logic [ADDR_W-1:0]  ex_wd;
  logic               ex_wreg;
  logic [DATA_W-1:0]  ex_wdata;
  logic [DATA_W-1:0]  ex_hi;
  logic [DATA_W-1:0]  ex_lo;
  logic               ex_whilo;
  logic [ALUOP_W-1:0] ex_aluop;
  logic [DATA_W-1:0]  ex_mem_addr;
  logic [DATA_W-1:0]  ex_reg2;
  logic [HILO_W-1:0]  hilo_i;
  logic [CNT_W-1:0]   cnt_i;

  logic [ADDR_W-1:0]  mem_wd;
  logic               mem_wreg;
  logic [DATA_W-1:0]  mem_wdata;
  logic [DATA_W-1:0]  mem_hi;
  logic [DATA_W-1:0]  mem_lo;
  logic               mem_whilo;
  logic [ALUOP_W-1:0] mem_aluop;
  logic [DATA_W-1:0]  mem_mem_addr;
  logic [DATA_W-1:0]  mem_reg2;
  logic [HILO_W-1:0]  hilo_o;
  logic [CNT_W-1:0]   cnt_o;

  modport master (
    output ex_wd, ex_wreg, ex_wdata, ex_hi, ex_lo, ex_whilo, ex_aluop,
           ex_mem_addr, ex_reg2, hilo_i, cnt_i,
    input  mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo, mem_aluop,
           mem_mem_addr, mem_reg2, hilo_o, cnt_o
  );

  modport slave (
    input  ex_wd, ex_wreg, ex_wdata, ex_hi, ex_lo, ex_whilo, ex_aluop,
           ex_mem_addr, ex_reg2, hilo_i, cnt_i,
    output mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo, mem_aluop,
           mem_mem_addr, mem_reg2, hilo_o, cnt_o
  );

endinterface

// File: rtl/ex_mem.sv
// Execute/memory pipeline register with flush, stall-driven bubble/hold,
// and holding of the multi-cycle accumulate state for the execute stage.
module ex_mem
  import ex_mem_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  ex_mem_if.slave            bus
);

  ex_mem_pl_t        ex_pl;
  ex_mem_pl_t        pl_d,   pl_q;
  logic [HILO_W-1:0] hilo_d, hilo_q;
  logic [CNT_W-1:0]  cnt_d,  cnt_q;
  logic              stall_ex, stall_mem;

  assign stall_ex  = stall[STALL_EX];
  assign stall_mem = stall[STALL_MEM];

  // Other stages' stall bits do not affect this register.
  logic unused_stall;
  assign unused_stall = ^{stall[5], stall[2:0]};

  always_comb begin
    ex_pl          = '0;
    ex_pl.wd       = bus.ex_wd;
    ex_pl.wreg     = bus.ex_wreg;
    ex_pl.wdata    = bus.ex_wdata;
    ex_pl.hi       = bus.ex_hi;
    ex_pl.lo       = bus.ex_lo;
    ex_pl.whilo    = bus.ex_whilo;
    ex_pl.aluop    = bus.ex_aluop;
    ex_pl.mem_addr = bus.ex_mem_addr;
    ex_pl.reg2     = bus.ex_reg2;
  end

  // Next state: flush beats stall; the illegal E=0,M=1 pattern holds like E=1,M=1.
  always_comb begin
    pl_d   = pl_q;
    hilo_d = hilo_q;
    cnt_d  = cnt_q;
    if (flush) begin
      pl_d   = bubble_pl();
      hilo_d = '0;
      cnt_d  = '0;
    end else if (!stall_ex && !stall_mem) begin
      pl_d   = ex_pl;
      hilo_d = '0;
      cnt_d  = '0;
    end else if (stall_ex && !stall_mem) begin
      pl_d   = bubble_pl();
      hilo_d = bus.hilo_i;
      cnt_d  = bus.cnt_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pl_q   <= '0;
      hilo_q <= '0;
      cnt_q  <= '0;
    end else begin
      pl_q   <= pl_d;
      hilo_q <= hilo_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.mem_wd       = pl_q.wd;
  assign bus.mem_wreg     = pl_q.wreg;
  assign bus.mem_wdata    = pl_q.wdata;
  assign bus.mem_hi       = pl_q.hi;
  assign bus.mem_lo       = pl_q.lo;
  assign bus.mem_whilo    = pl_q.whilo;
  assign bus.mem_aluop    = pl_q.aluop;
  assign bus.mem_mem_addr = pl_q.mem_addr;
  assign bus.mem_reg2     = pl_q.reg2;
  assign bus.hilo_o       = hilo_q;
  assign bus.cnt_o        = cnt_q;

endmodule

// File: tb/tb_ex_mem.sv
// Self-checking bench for ex_mem: directed test-plan steps plus random
// stall/flush/reset traffic, checked through an expected-output queue.
module tb_ex_mem;
  import ex_mem_pkg::*;

  typedef struct {
    ex_mem_pl_t        pl;
    logic [HILO_W-1:0] hilo;
    logic [CNT_W-1:0]  cnt;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst;
  logic [STALL_W-1:0] stall;
  logic               flush;

  ex_mem_if bus();

  ex_mem dut (
    .clk   (clk),
    .rst   (rst),
    .stall (stall),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];
  exp_t m;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour for one rising edge.
  task automatic model_step();
    ex_mem_pl_t in_pl;
    in_pl = '{wd: bus.ex_wd, wreg: bus.ex_wreg, wdata: bus.ex_wdata, hi: bus.ex_hi,
              lo: bus.ex_lo, whilo: bus.ex_whilo, aluop: bus.ex_aluop,
              mem_addr: bus.ex_mem_addr, reg2: bus.ex_reg2};
    if (rst || flush) begin
      m.pl = '0; m.hilo = '0; m.cnt = '0;
    end else begin
      case ({stall[4], stall[3]})
        2'b00: begin m.pl = in_pl; m.hilo = '0; m.cnt = '0; end
        2'b01: begin m.pl = '0; m.hilo = bus.hilo_i; m.cnt = bus.cnt_i; end
        default: ;
      endcase
    end
  endtask

  task automatic compare_out(input exp_t e);
    check_eq("mem_wd",       64'(bus.mem_wd),       64'(e.pl.wd));
    check_eq("mem_wreg",     64'(bus.mem_wreg),     64'(e.pl.wreg));
    check_eq("mem_wdata",    64'(bus.mem_wdata),    64'(e.pl.wdata));
    check_eq("mem_hi",       64'(bus.mem_hi),       64'(e.pl.hi));
    check_eq("mem_lo",       64'(bus.mem_lo),       64'(e.pl.lo));
    check_eq("mem_whilo",    64'(bus.mem_whilo),    64'(e.pl.whilo));
    check_eq("mem_aluop",    64'(bus.mem_aluop),    64'(e.pl.aluop));
    check_eq("mem_mem_addr", 64'(bus.mem_mem_addr), 64'(e.pl.mem_addr));
    check_eq("mem_reg2",     64'(bus.mem_reg2),     64'(e.pl.reg2));
    check_eq("hilo_o",       64'(bus.hilo_o),       64'(e.hilo));
    check_eq("cnt_o",        64'(bus.cnt_o),        64'(e.cnt));
  endtask

  // Push expectation for the current inputs, clock once, pop and compare.
  task automatic cycle();
    exp_t e;
    model_step();
    sb_q.push_back(m);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_eq("scoreboard_empty", 64'(1), 64'(0));
    end else begin
      e = sb_q.pop_front();
      compare_out(e);
    end
  endtask

  task automatic set_ex_all(input logic [31:0] v);
    bus.ex_wd       = ADDR_W'(v);
    bus.ex_wreg     = 1'b1;
    bus.ex_wdata    = v;
    bus.ex_hi       = ~v;
    bus.ex_lo       = v ^ 32'h0F0F_0F0F;
    bus.ex_whilo    = 1'b1;
    bus.ex_aluop    = ALUOP_W'(v) | 8'h01;
    bus.ex_mem_addr = v + 32'd4;
    bus.ex_reg2     = v - 32'd1;
    bus.hilo_i      = {v, ~v};
    bus.cnt_i       = 2'd3;
  endtask

  initial begin
    m = '{pl: '0, hilo: '0, cnt: '0};
    rst = 1'b1; flush = 1'b0; stall = '0;
    set_ex_all(32'hCAFE_F00D);
    #1;

    // Reset with every input non-zero.
    cycle();
    cycle();
    check_eq("rst_wreg",   64'(bus.mem_wreg),  64'(0));
    check_eq("rst_hilo_o", 64'(bus.hilo_o),    64'(0));
    check_eq("rst_cnt_o",  64'(bus.cnt_o),     64'(0));

    rst = 1'b0;
    bus.ex_wdata = 32'h1234_5678;
    cycle();
    check_eq("first_load_wdata", 64'(bus.mem_wdata), 64'h1234_5678);

    // Normal pass.
    bus.ex_wd = 5'd5; bus.ex_wreg = 1'b1; bus.ex_whilo = 1'b1;
    bus.ex_hi = 32'hAAAA_0001; bus.ex_lo = 32'h5555_0002;
    cycle();
    check_eq("pass_wd",   64'(bus.mem_wd), 64'(5));
    check_eq("pass_hi",   64'(bus.mem_hi), 64'hAAAA_0001);
    check_eq("pass_lo",   64'(bus.mem_lo), 64'h5555_0002);
    check_eq("pass_hilo", 64'(bus.hilo_o), 64'(0));

    // Accumulate stall then release.
    stall = 6'b001000;
    bus.hilo_i = 64'h0000_0001_FFFF_FFFE; bus.cnt_i = 2'd1;
    cycle();
    check_eq("acc_wreg",  64'(bus.mem_wreg),  64'(0));
    check_eq("acc_whilo", 64'(bus.mem_whilo), 64'(0));
    check_eq("acc_hilo",  64'(bus.hilo_o),    64'h0000_0001_FFFF_FFFE);
    check_eq("acc_cnt",   64'(bus.cnt_o),     64'(1));
    stall = '0;
    cycle();
    check_eq("rel_hilo", 64'(bus.hilo_o), 64'(0));
    check_eq("rel_cnt",  64'(bus.cnt_o),  64'(0));
    check_eq("rel_wreg", 64'(bus.mem_wreg), 64'(1));

    // Full hold.
    bus.ex_wdata = 32'hDEAD_BEEF;
    cycle();
    stall = 6'b011000;
    for (int i = 0; i < 3; i++) begin
      bus.ex_wdata = 32'h1111_0000 + 32'(i);
      cycle();
      check_eq("hold_wdata", 64'(bus.mem_wdata), 64'hDEAD_BEEF);
    end

    // Flush beats a full stall; accumulate state set first so the clear is visible.
    stall = 6'b001000; bus.hilo_i = 64'h1234_5678_9ABC_DEF0; bus.cnt_i = 2'd2;
    cycle();
    stall = '0; bus.ex_wreg = 1'b1; bus.ex_aluop = 8'h23;
    cycle();
    stall = 6'b001000;
    cycle();
    stall = 6'b011000; flush = 1'b1;
    cycle();
    check_eq("flush_wreg",  64'(bus.mem_wreg),  64'(0));
    check_eq("flush_aluop", 64'(bus.mem_aluop), 64'(0));
    check_eq("flush_hilo",  64'(bus.hilo_o),    64'(0));
    flush = 1'b0;

    // Reset mid-accumulate.
    stall = '0; set_ex_all(32'h0BAD_F00D);
    cycle();
    stall = 6'b001000; bus.cnt_i = 2'd1;
    cycle();
    stall = 6'b011000;
    cycle();
    check_eq("midacc_cnt_held", 64'(bus.cnt_o), 64'(1));
    rst = 1'b1;
    cycle();
    check_eq("midacc_rst_cnt",   64'(bus.cnt_o),     64'(0));
    check_eq("midacc_rst_hilo",  64'(bus.hilo_o),    64'(0));
    check_eq("midacc_rst_wdata", 64'(bus.mem_wdata), 64'(0));
    rst = 1'b0;

    // Illegal pattern E=0,M=1 holds everything.
    stall = '0; set_ex_all(32'h7777_1234);
    cycle();
    stall = 6'b010000; set_ex_all(32'h0000_9999);
    cycle();
    check_eq("illegal_hold_wdata", 64'(bus.mem_wdata), 64'h7777_1234);

    // Random traffic.
    for (int i = 0; i < 80; i++) begin
      logic [2:0] sel;
      sel = 3'($urandom_range(0, 7));
      case (sel)
        3'd0, 3'd1, 3'd2: stall = 6'b000000;
        3'd3, 3'd4:       stall = 6'b001000 | 6'($urandom_range(0, 7));
        3'd5, 3'd6:       stall = 6'b011000;
        default:          stall = 6'b010000;
      endcase
      stall[5] = 1'($urandom_range(0, 1));
      flush = ($urandom_range(0, 7) == 0);
      rst   = ($urandom_range(0, 19) == 0);
      set_ex_all($urandom);
      bus.ex_wreg  = 1'($urandom_range(0, 1));
      bus.ex_whilo = 1'($urandom_range(0, 1));
      bus.hilo_i   = {$urandom, $urandom};
      bus.cnt_i    = 2'($urandom_range(0, 3));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_mem.md
# ex_mem

Pipeline register between the execute stage and the memory stage of the five-stage integer core. It captures the execute-stage results: register write-back, HI/LO write-back, and load/store operands. The capture is controlled by the core-wide stall vector and a flush line. It also holds the two-cycle accumulate state (64-bit partial product plus cycle counter) and returns it to the execute stage while that stage stalls for multi-cycle multiply-accumulate.

## Interface
Parameters:
- DATA_W, 32, general-purpose / HI / LO data width
- ADDR_W, 5, register-file address width
- ALUOP_W, 8, ALU operation code width
- CNT_W, 2, multi-cycle step counter width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- stall  in  6  core stall vector; bit 3 = execute stalled, bit 4 = memory stalled
- flush  in  1  discard the in-flight instruction (exception/branch recovery)
- ex_wd  in  ADDR_W  destination register address
- ex_wreg  in  1  register write enable
- ex_wdata  in  DATA_W  register write data
- ex_hi, ex_lo  in  DATA_W  HI/LO write data
- ex_whilo  in  1  HI/LO write enable
- ex_aluop  in  ALUOP_W  operation code, forwarded for load/store decode
- ex_mem_addr  in  DATA_W  effective memory address
- ex_reg2  in  DATA_W  store data
- hilo_i  in  2*DATA_W  partial accumulate product from execute
- cnt_i  in  CNT_W  accumulate step from execute
- mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo, mem_aluop, mem_mem_addr, mem_reg2  out  (matching widths)  registered copies to the memory stage
- hilo_o  out  2*DATA_W  held partial product back to execute
- cnt_o  out  CNT_W  held step back to execute

## Operation
- All outputs are registers, updated only on rising clk.
- Reset (rst=1): every output is 0, including hilo_o and cnt_o. This applies mid-stall and mid-accumulate.
- Priority at each edge is rst, then flush, then stall rules.
- flush=1: all mem_* outputs become 0 (a bubble). hilo_o and cnt_o become 0.
- Stall rules, with E = stall[3] and M = stall[4]:
  - E=0, M=0: capture all ex_* into mem_*. Set hilo_o=0 and cnt_o=0.
  - E=1, M=0: insert a bubble; mem_* become 0, i.e. mem_wreg=0, mem_whilo=0, mem_aluop=NOP(0). Capture hilo_i into hilo_o and cnt_i into cnt_o.
  - E=1, M=1: hold all mem_* outputs, hilo_o and cnt_o.
  - E=0, M=1: illegal stall pattern (the stall controller never produces it). The block holds all outputs.
- Data are passed through unmodified; no width conversion or arithmetic. hilo_o is the full 2*DATA_W value; cnt_o is the unsigned step index.
- A bubble never asserts mem_wreg or mem_whilo. This ensures forwarding from the memory stage never sees stale data.

## Timing
- Latency: one cycle, ex_* to mem_*.
- hilo_o/cnt_o are valid one cycle after execute raised its stall. They remain stable while E=1, M=0 is repeated, because execute presents the same hilo_i/cnt_i on each of those cycles.
- They clear on the first non-stalled edge, so a subsequent accumulate starts from step 0.
- flush together with any stall pattern still produces a bubble.
- After rst deasserts, the first edge with E=0, M=0 loads the first instruction.

## Structure
- Stall bit indices (EX=3, MEM=4), the NOP aluop code, and the data/address widths come from the shared core definitions package. They are not redefined locally.
- The block is a single module with no sub-modules. A generic enable/clear register is not warranted.

## Test plan
- Reset: drive all ex_* non-zero with rst=1 for 2 cycles -> all outputs 0. Then release with stall=0 and ex_wdata=0x1234_5678 -> mem_wdata=0x1234_5678 one edge later.
- Normal pass: stall=0, ex_wd=5, ex_wreg=1, ex_whilo=1, ex_hi=0xAAAA_0001, ex_lo=0x5555_0002 -> same values on mem_* next cycle. hilo_o=0, cnt_o=0.
- Accumulate stall: stall=6'b001000, hilo_i=0x0000_0001_FFFF_FFFE, cnt_i=1 for 1 cycle -> mem_wreg=0, mem_whilo=0, hilo_o=0x0000_0001_FFFF_FFFE, cnt_o=1. Next cycle stall=0 -> hilo_o=0, cnt_o=0, and ex_* are captured.
- Full hold: load ex_wdata=0xDEAD_BEEF, then stall=6'b011000 for 3 cycles while ex_wdata changes -> mem_wdata stays 0xDEAD_BEEF.
- Flush priority: stall=6'b011000 with flush=1 while holding wreg=1 -> next edge mem_wreg=0, mem_aluop=0, hilo_o=0.
- Reset mid-accumulate: cnt_o=1 held under stall, assert rst for one edge -> cnt_o=0, hilo_o=0, and all mem_* are 0.
